// File: rtl/slave_in.sv
// slave_in: serial bus slave front end.
//
// A write transaction carries a serial header (address LSB first, burst count
// preceded by one marker bit) and a stream of serial data words. Each
// assembled word is committed to local memory as a one-cycle write strobe at
// base address + beat index. A read transaction carries only the address and
// produces a one-cycle read request.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   slave_sel       this slave addressed by the bus decoder
//   write_en        master write request (wins over read_en)
//   read_en         master read request
//   master_valid    rx_data bit valid this cycle
//   rx_address      serial address bit
//   rx_data         serial data bit
//   rx_burst_number serial burst-count bit (marker first)
//   slave_ready     low only for the single DONE cycle
//   mem_we          one-cycle local memory write strobe
//   mem_addr        write address (held while mem_we is low)
//   mem_wdata       write data (held while mem_we is low)
//   rd_req          one-cycle read request
//   rd_addr         read address, held until the next rd_req
//   write_done      one-cycle pulse after the final write beat
module slave_in #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                slave_sel,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                master_valid,
    input  logic                rx_address,
    input  logic                rx_data,
    input  logic                rx_burst_number,
    output logic                slave_ready,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                rd_req,
    output logic [ADDR_LEN-1:0] rd_addr,
    output logic                write_done
);

    // Last header cycle: address occupies cycles 0..ADDR_LEN-1, burst bits
    // occupy cycles 1..BURST_LEN (cycle 0 carries the marker).
    localparam int HDR_LAST = (ADDR_LEN - 1 > BURST_LEN) ? ADDR_LEN - 1 : BURST_LEN;
    localparam int HDR_W    = $clog2(HDR_LAST + 2);
    localparam int BIT_W    = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

    localparam logic [HDR_W-1:0] HDR_LAST_C  = HDR_W'(HDR_LAST);
    localparam logic [HDR_W-1:0] ADDR_LAST_C = HDR_W'(ADDR_LEN - 1);
    localparam logic [HDR_W-1:0] ADDR_LEN_C  = HDR_W'(ADDR_LEN);
    localparam logic [HDR_W-1:0] BURST_LEN_C = HDR_W'(BURST_LEN);
    localparam logic [BIT_W-1:0] BIT_LAST_C  = BIT_W'(DATA_LEN - 1);

    typedef enum logic [1:0] {IDLE, WR_RX, RD_RX, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [HDR_W-1:0]       hdr_cnt_reg;
    logic                   hdr_done_reg;
    logic [ADDR_LEN-1:0]    addr_reg;
    logic [BURST_LEN-1:0]   burst_reg;
    logic [BIT_W-1:0]       bit_cnt_reg;
    logic [DATA_LEN-2:0]    word_reg;      // partial word, top bits only
    logic [DATA_LEN-1:0]    hold_reg;      // completed word awaiting commit
    logic                   pend_reg;
    logic [BURST_LEN-1:0]   beat_cnt_reg;
    logic [3:0]             idle_cnt_reg;
    logic                   is_wr_reg;
    logic                   mem_we_reg;
    logic [ADDR_LEN-1:0]    mem_addr_reg;
    logic [DATA_LEN-1:0]    mem_wdata_reg;
    logic                   rd_req_reg;
    logic [ADDR_LEN-1:0]    rd_addr_reg;

    logic [DATA_LEN-1:0]    word_next;
    logic [ADDR_LEN-1:0]    addr_next;
    logic [BURST_LEN-1:0]   beats;
    logic                   word_done;
    logic                   commit;
    logic                   all_done;
    logic                   timeout;
    logic                   rd_issue;

    assign word_next = {rx_data, word_reg};
    assign addr_next = {rx_address, addr_reg[ADDR_LEN-1:1]};
    assign beats     = (burst_reg == '0) ? BURST_LEN'(1) : burst_reg;
    assign word_done = (state_reg == WR_RX) && master_valid && (bit_cnt_reg == BIT_LAST_C);
    // A completed word waits in hold_reg until the header is fully known.
    assign commit    = (state_reg == WR_RX) && slave_sel && pend_reg && hdr_done_reg
                       && (beat_cnt_reg != beats);
    assign all_done  = hdr_done_reg && (beat_cnt_reg == beats);
    assign timeout   = hdr_done_reg && !master_valid && (idle_cnt_reg == 4'd15);
    assign rd_issue  = (state_reg == RD_RX) && slave_sel && !hdr_done_reg && !rd_req_reg
                       && (hdr_cnt_reg == ADDR_LAST_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        slave_ready = 1'b1;
        write_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (slave_sel && write_en) begin
                    state_next = WR_RX;
                end else if (slave_sel && read_en) begin
                    state_next = RD_RX;
                end
            end
            WR_RX: begin
                if (!slave_sel) begin
                    state_next = IDLE;
                end else if (all_done) begin
                    state_next = DONE;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            RD_RX: begin
                if (!slave_sel) begin
                    state_next = IDLE;
                end else if (rd_req_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                slave_ready = 1'b0;
                write_done  = is_wr_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_cnt_reg   <= '0;
            hdr_done_reg  <= 1'b0;
            addr_reg      <= '0;
            burst_reg     <= '0;
            bit_cnt_reg   <= '0;
            word_reg      <= '0;
            hold_reg      <= '0;
            pend_reg      <= 1'b0;
            beat_cnt_reg  <= '0;
            idle_cnt_reg  <= '0;
            is_wr_reg     <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rd_req_reg    <= 1'b0;
            rd_addr_reg   <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            rd_req_reg <= 1'b0;
            if (state_reg == IDLE) begin
                // Working state is held clear so every transaction starts fresh.
                hdr_cnt_reg  <= '0;
                hdr_done_reg <= 1'b0;
                addr_reg     <= '0;
                burst_reg    <= '0;
                bit_cnt_reg  <= '0;
                word_reg     <= '0;
                hold_reg     <= '0;
                pend_reg     <= 1'b0;
                beat_cnt_reg <= '0;
                idle_cnt_reg <= '0;
                is_wr_reg    <= write_en;
            end else if ((state_reg == WR_RX || state_reg == RD_RX) && slave_sel) begin
                if (!hdr_done_reg) begin
                    if (hdr_cnt_reg < ADDR_LEN_C) begin
                        addr_reg <= addr_next;
                    end
                    if ((state_reg == WR_RX) && (hdr_cnt_reg != '0)
                        && (hdr_cnt_reg <= BURST_LEN_C)) begin
                        burst_reg <= {rx_burst_number, burst_reg[BURST_LEN-1:1]};
                    end
                    if (hdr_cnt_reg == HDR_LAST_C) begin
                        hdr_done_reg <= 1'b1;
                    end else begin
                        hdr_cnt_reg <= hdr_cnt_reg + 1'b1;
                    end
                end
                if (rd_issue) begin
                    rd_req_reg  <= 1'b1;
                    rd_addr_reg <= addr_next;
                end
                if (state_reg == WR_RX) begin
                    if (master_valid) begin
                        idle_cnt_reg <= '0;
                        word_reg     <= word_next[DATA_LEN-1:1];
                        if (word_done) begin
                            bit_cnt_reg <= '0;
                            hold_reg    <= word_next;
                            pend_reg    <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else if (hdr_done_reg) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                    if (commit) begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= addr_reg + ADDR_LEN'(beat_cnt_reg);
                        mem_wdata_reg <= hold_reg;
                        beat_cnt_reg  <= beat_cnt_reg + 1'b1;
                        if (!word_done) begin
                            pend_reg <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign rd_req    = rd_req_reg;
    assign rd_addr   = rd_addr_reg;

endmodule

// File: tb/tb_slave_in.sv
// Scoreboard bench for slave_in: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_slave_in;

    logic        clk = 1'b0;
    logic        reset, slave_sel, write_en, read_en, master_valid;
    logic        rx_address, rx_data, rx_burst_number;
    logic        slave_ready, mem_we, rd_req, write_done;
    logic [11:0] mem_addr, rd_addr;
    logic [7:0]  mem_wdata;

    always #5 clk = ~clk;

    slave_in #(.ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12)) dut (
        .clk(clk), .reset(reset), .slave_sel(slave_sel), .write_en(write_en),
        .read_en(read_en), .master_valid(master_valid), .rx_address(rx_address),
        .rx_data(rx_data), .rx_burst_number(rx_burst_number),
        .slave_ready(slave_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .rd_req(rd_req), .rd_addr(rd_addr),
        .write_done(write_done)
    );

    localparam logic [1:0] K_WE = 2'd0;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_WD = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [11:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   notready_cnt = 0;
    int   nr0 = 0;
    logic prev_we = 1'b0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [11:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [1:0] k, input logic [11:0] a, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=kind%0d addr=0x%0h data=0x%0h required=none",
                     k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.addr !== a || e.data !== d) begin
                failures++;
                $display("FAIL event actual=kind%0d addr=0x%0h data=0x%0h required=kind%0d addr=0x%0h data=0x%0h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (!slave_ready) notready_cnt++;
            if (mem_we) observe(K_WE, mem_addr, mem_wdata);
            if (rd_req) observe(K_RD, rd_addr, 8'h00);
            if (write_done) begin
                observe(K_WD, 12'h000, 8'h00);
                check_val("write_done_after_we", {31'd0, prev_we}, 32'd1);
            end
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic check_reset(input string tag);
        check_val({tag, "_ready"}, {31'd0, slave_ready}, 32'd1);
        check_val({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check_val({tag, "_rd_req"}, {31'd0, rd_req}, 32'd0);
        check_val({tag, "_write_done"}, {31'd0, write_done}, 32'd0);
        check_val({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
        check_val({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check_val({tag, "_rd_addr"}, {20'd0, rd_addr}, 32'd0);
    endtask

    task automatic clear_rx();
        master_valid    = 1'b0;
        rx_address      = 1'b0;
        rx_data         = 1'b0;
        rx_burst_number = 1'b0;
    endtask

    task automatic txn_start();
        nr0 = notready_cnt;
    endtask

    task automatic txn_end(input string name, input int exp_nr);
        check_val({name, "_notready_cycles"}, notready_cnt - nr0, exp_nr);
        check_val({name, "_events_drained"}, exp_q.size(), 0);
        $display("txn %s checks=%0d", name, checks);
    endtask

    // mode 0: normal, 1: drop slave_sel at cycle stop_k, 2: assert reset at cycle stop_k
    task automatic send_write(input logic [11:0] addr, input logic [11:0] burst,
                              input logic [31:0] words, input int nbits, input int mode,
                              input int stop_k, input bit both, input int tail,
                              input int post_bits);
        int ncyc;
        ncyc = (nbits > 13) ? nbits : 13;
        slave_sel = 1'b1;
        write_en  = 1'b1;
        read_en   = both;
        @(posedge clk); #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (mode != 0 && k == stop_k) begin
                if (mode == 1) begin
                    slave_sel = 1'b0;
                end else begin
                    reset = 1'b0;
                    #1;
                    check_reset("midword_reset");
                end
                break;
            end
            rx_address      = (k < 12) ? addr[k] : 1'b0;
            rx_burst_number = (k == 0) ? 1'b1 : ((k <= 12) ? burst[k-1] : 1'b0);
            master_valid    = (k < nbits);
            rx_data         = (k < nbits) ? words[k] : 1'b0;
            @(posedge clk); #1;
        end
        clear_rx();
        if (mode == 2) begin
            slave_sel = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check_reset("held_reset");
            reset = 1'b1;
        end else begin
            repeat (tail) @(posedge clk);
            #1;
            for (int p = 0; p < post_bits; p++) begin
                master_valid = 1'b1;
                rx_data      = 1'b1;
                @(posedge clk); #1;
            end
            clear_rx();
            slave_sel = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_read(input logic [11:0] addr);
        slave_sel = 1'b1;
        read_en   = 1'b1;
        @(posedge clk); #1;
        read_en = 1'b0;
        for (int k = 0; k < 12; k++) begin
            rx_address      = addr[k];
            master_valid    = 1'b1;
            rx_data         = k[0];
            rx_burst_number = 1'b1;
            @(posedge clk); #1;
        end
        clear_rx();
        repeat (5) @(posedge clk);
        #1;
        slave_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        slave_sel = 1'b0;
        write_en = 1'b0;
        read_en = 1'b0;
        clear_rx();
        repeat (2) @(posedge clk);
        #1;
        check_reset("power_on_reset");
        reset = 1'b1;
        @(posedge clk); #1;

        txn_start();
        expect_ev(K_WE, 12'h123, 8'hA5);
        expect_ev(K_WD, 12'h000, 8'h00);
        send_write(12'h123, 12'd0, 32'h0000_00A5, 8, 0, 0, 1'b0, 10, 0);
        txn_end("single_write", 1);

        txn_start();
        expect_ev(K_WE, 12'h0FE, 8'h11);
        expect_ev(K_WE, 12'h0FF, 8'h22);
        expect_ev(K_WE, 12'h100, 8'h33);
        expect_ev(K_WD, 12'h000, 8'h00);
        send_write(12'h0FE, 12'd3, 32'h0033_2211, 24, 0, 0, 1'b0, 10, 0);
        txn_end("burst_write", 1);
        check_val("mem_addr_hold", {20'd0, mem_addr}, 32'h100);
        check_val("mem_wdata_hold", {24'd0, mem_wdata}, 32'h33);

        txn_start();
        expect_ev(K_WE, 12'hFFF, 8'h5A);
        expect_ev(K_WE, 12'h000, 8'hC3);
        expect_ev(K_WD, 12'h000, 8'h00);
        send_write(12'hFFF, 12'd2, 32'h0000_C35A, 16, 0, 0, 1'b0, 10, 0);
        txn_end("wrap_write", 1);

        txn_start();
        expect_ev(K_RD, 12'h3C4, 8'h00);
        send_read(12'h3C4);
        txn_end("read", 1);
        check_val("rd_addr_hold", {20'd0, rd_addr}, 32'h3C4);

        txn_start();
        send_write(12'h0F0, 12'd0, 32'h0000_00FF, 8, 1, 4, 1'b0, 5, 0);
        txn_end("abort_sel", 0);
        check_val("abort_ready", {31'd0, slave_ready}, 32'd1);
        check_val("abort_mem_we", {31'd0, mem_we}, 32'd0);

        txn_start();
        send_write(12'h321, 12'd0, 32'h0000_00FF, 8, 2, 3, 1'b0, 0, 0);
        txn_end("abort_reset", 0);

        txn_start();
        expect_ev(K_WE, 12'h456, 8'h81);
        expect_ev(K_WD, 12'h000, 8'h00);
        send_write(12'h456, 12'd0, 32'h0000_0081, 8, 0, 0, 1'b0, 10, 0);
        txn_end("write_after_reset", 1);

        txn_start();
        expect_ev(K_WE, 12'h0AA, 8'h3C);
        expect_ev(K_WD, 12'h000, 8'h00);
        send_write(12'h0AA, 12'd0, 32'h0000_003C, 8, 0, 0, 1'b1, 10, 0);
        txn_end("write_wins", 1);

        // Only beat 0 arrives; after the timeout, further valid bits must be ignored.
        txn_start();
        expect_ev(K_WE, 12'h200, 8'h77);
        send_write(12'h200, 12'd3, 32'h0000_0077, 8, 0, 0, 1'b0, 30, 10);
        txn_end("timeout", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
